// File: rtl/ml_metric_calc.sv
// ML timing metric: lambda = |gamma| - (phi >> RHO_SHIFT), 5-stage pipeline.
// Defining LAMBDA_SAT_CNT_EN adds the saturating clip-event counter sat_cnt.
module ml_metric_calc #(
    parameter int N         = 256,
    parameter int L         = 16,
    parameter int RHO_SHIFT = 2,
    parameter int OUT_SHIFT = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [15:0] r_re,
    input  logic signed [15:0] r_im,
    output logic               minus_valid,
    output logic signed [15:0] lambda
`ifdef LAMBDA_SAT_CNT_EN
    ,
    output logic [15:0]        sat_cnt
`endif
);
    localparam int NW = $clog2(N);
    localparam int LW = $clog2(L);

    // S1: sample delay line, read-before-write gives r(k-N)
    logic signed [15:0] dre_q [N];
    logic signed [15:0] dim_q [N];
    logic [NW-1:0]      wptr_q;
    logic               v1_q;
    logic signed [15:0] are_q, aim_q, bre_q, bim_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                dre_q[i] <= '0;
                dim_q[i] <= '0;
            end
            wptr_q <= '0;
            v1_q   <= 1'b0;
            are_q  <= '0;
            aim_q  <= '0;
            bre_q  <= '0;
            bim_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                are_q         <= r_re;
                aim_q         <= r_im;
                bre_q         <= dre_q[wptr_q];
                bim_q         <= dim_q[wptr_q];
                dre_q[wptr_q] <= r_re;
                dim_q[wptr_q] <= r_im;
                wptr_q        <= (wptr_q == NW'(N - 1)) ? '0 : wptr_q + NW'(1);
            end
        end
    end

    // S2: correlation product and energy
    logic signed [31:0] m_rr, m_ii, m_ir, m_ri;
    logic [31:0]        sq_ar, sq_ai, sq_br, sq_bi;
    logic signed [32:0] pre_d, pim_d;
    logic [33:0]        e_d;
    logic signed [32:0] pre_q, pim_q;
    logic [33:0]        e_q;
    logic               v2_q;

    always_comb begin
        m_rr  = 32'(are_q) * 32'(bre_q);
        m_ii  = 32'(aim_q) * 32'(bim_q);
        m_ir  = 32'(aim_q) * 32'(bre_q);
        m_ri  = 32'(are_q) * 32'(bim_q);
        sq_ar = 32'(are_q) * 32'(are_q);
        sq_ai = 32'(aim_q) * 32'(aim_q);
        sq_br = 32'(bre_q) * 32'(bre_q);
        sq_bi = 32'(bim_q) * 32'(bim_q);
        pre_d = 33'(m_rr) + 33'(m_ii);
        pim_d = 33'(m_ir) - 33'(m_ri);
        e_d   = 34'(sq_ar) + 34'(sq_ai) + 34'(sq_br) + 34'(sq_bi);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            pre_q <= '0;
            pim_q <= '0;
            e_q   <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                pre_q <= pre_d;
                pim_q <= pim_d;
                e_q   <= e_d;
            end
        end
    end

    // S3: sliding-window sums over the last L terms
    logic signed [32:0] hre_q [L];
    logic signed [32:0] him_q [L];
    logic [33:0]        he_q  [L];
    logic [LW-1:0]      pptr_q;
    logic signed [36:0] gre_q, gim_q;
    logic [37:0]        psum_q;
    logic               v3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                hre_q[i] <= '0;
                him_q[i] <= '0;
                he_q[i]  <= '0;
            end
            pptr_q <= '0;
            gre_q  <= '0;
            gim_q  <= '0;
            psum_q <= '0;
            v3_q   <= 1'b0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                gre_q         <= gre_q + 37'(pre_q) - 37'(hre_q[pptr_q]);
                gim_q         <= gim_q + 37'(pim_q) - 37'(him_q[pptr_q]);
                psum_q        <= psum_q + 38'(e_q) - 38'(he_q[pptr_q]);
                hre_q[pptr_q] <= pre_q;
                him_q[pptr_q] <= pim_q;
                he_q[pptr_q]  <= e_q;
                pptr_q        <= pptr_q + LW'(1);
            end
        end
    end

    // S4: max + min/2 magnitude estimate; phi is captured alongside
    logic [36:0] abs_re, abs_im, mx, mn;
    logic [37:0] mag_d;
    logic [37:0] mag_q, ps_q;
    logic        v4_q;

    always_comb begin
        abs_re = gre_q[36] ? 37'(-gre_q) : 37'(gre_q);
        abs_im = gim_q[36] ? 37'(-gim_q) : 37'(gim_q);
        mx     = (abs_re >= abs_im) ? abs_re : abs_im;
        mn     = (abs_re >= abs_im) ? abs_im : abs_re;
        mag_d  = 38'(mx) + 38'(mn >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v4_q  <= 1'b0;
            mag_q <= '0;
            ps_q  <= '0;
        end else begin
            v4_q <= v3_q;
            if (v3_q) begin
                mag_q <= mag_d;
                ps_q  <= psum_q >> RHO_SHIFT;
            end
        end
    end

    // S5: subtract, floor shift, clip
    logic signed [38:0] diff_d, q_d;
    logic signed [15:0] lambda_d, lambda_q;
    logic               mv_q;

    always_comb begin
        diff_d = signed'(39'(mag_q)) - signed'(39'(ps_q));
        q_d    = diff_d >>> OUT_SHIFT;
        if (q_d > 39'sd32767)
            lambda_d = 16'sh7fff;
        else if (q_d < -39'sd32768)
            lambda_d = 16'sh8000;
        else
            lambda_d = q_d[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv_q     <= 1'b0;
            lambda_q <= '0;
        end else begin
            mv_q <= v4_q;
            if (v4_q)
                lambda_q <= lambda_d;
        end
    end

    assign minus_valid = mv_q;
    assign lambda      = lambda_q;

`ifdef LAMBDA_SAT_CNT_EN
    logic        sat_d;
    logic [15:0] sat_q;

    assign sat_d = (q_d > 39'sd32767) || (q_d < -39'sd32768);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_q <= '0;
        else if (v4_q && sat_d && (sat_q != 16'hFFFF))
            sat_q <= sat_q + 16'd1;
    end

    assign sat_cnt = sat_q;
`endif

endmodule

// File: tb/tb_ml_metric_calc.sv
// Directed bench for ml_metric_calc: latency, warm-up, gaps, clipping, reset.
// Checks sat_cnt too when built with LAMBDA_SAT_CNT_EN.
`timescale 1ns/1ps
module tb_ml_metric_calc;
    localparam int N = 256;
    localparam int L = 16;

    logic               clk      = 1'b0;
    logic               rst      = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] r_re     = '0;
    logic signed [15:0] r_im     = '0;
    logic               minus_valid;
    logic signed [15:0] lambda;
`ifdef LAMBDA_SAT_CNT_EN
    logic [15:0]        sat_cnt;
`endif

    int vectors = 0;
    int errors  = 0;
    logic signed [15:0] got[$];

    always #5 clk = ~clk;

    ml_metric_calc dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .r_re       (r_re),
        .r_im       (r_im),
        .minus_valid(minus_valid),
        .lambda     (lambda)
`ifdef LAMBDA_SAT_CNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    // Window sums for a constant-amplitude real stream, optionally sign-flipped at k=N
    function automatic longint model_q(int k, int amp, bit flip);
        longint a2, g, p, m;
        a2 = longint'(amp) * longint'(amp);
        g  = 0;
        p  = 0;
        for (int i = k - L + 1; i <= k; i++) begin
            if (i >= 0) begin
                p += a2;
                if (i >= N) begin
                    p += a2;
                    g += flip ? -a2 : a2;
                end
            end
        end
        m = (g < 0) ? -g : g;
        return (m - (p >>> 2)) >>> 10;
    endfunction

    function automatic logic signed [15:0] clip(longint q);
        if (q > 32767)
            return 16'sh7fff;
        if (q < -32768)
            return 16'sh8000;
        return 16'(q);
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_stream(input int amp, input int nsamp,
                              input int gap_pct, input bit flip);
        logic [4:0] vh;
        int sent;
        int cyc;
        vh   = '0;
        sent = 0;
        cyc  = 0;
        got.delete();
        while ((sent < nsamp || vh != 0) && cyc < 4 * nsamp + 100) begin
            @(posedge clk);
            #1;
            if (sent < nsamp && $urandom_range(0, 99) >= gap_pct) begin
                in_valid = 1'b1;
                r_re     = 16'((flip && sent >= N) ? -amp : amp);
                r_im     = '0;
                sent++;
            end else begin
                in_valid = 1'b0;
                r_re     = '0;
                r_im     = '0;
            end
            @(negedge clk);
            vectors++;
            if (minus_valid !== vh[4]) begin
                errors++;
                $display("FAIL latency cyc=%0d minus_valid=%b expected=%b",
                         cyc, minus_valid, vh[4]);
            end
            if (minus_valid === 1'b1)
                got.push_back(lambda);
            vh = {vh[3:0], in_valid};
            cyc++;
        end
        vectors++;
        if (sent < nsamp || vh != 0) begin
            errors++;
            $display("FAIL stream_timeout sent=%0d required=%0d", sent, nsamp);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (minus_valid !== 1'b0 || lambda !== 16'sd0) begin
                errors++;
                $display("FAIL reset_state minus_valid=%b lambda=%0d expected 0/0",
                         minus_valid, lambda);
            end
`ifdef LAMBDA_SAT_CNT_EN
            vectors++;
            if (sat_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_sat_cnt got=%0d expected=0", sat_cnt);
            end
`endif
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_zero();
        run_stream(0, 600, 0, 1'b0);
        vectors++;
        if (got.size() != 600) begin
            errors++;
            $display("FAIL zero_count got=%0d expected=600", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            vectors++;
            if (got[k] !== 16'sd0) begin
                errors++;
                $display("FAIL zero_lambda k=%0d got=%0d expected=0", k, got[k]);
            end
        end
    endtask

    task automatic test_const();
        apply_reset();
        run_stream(1000, 400, 0, 1'b0);
        vectors += 4;
        if (got.size() != 400) begin
            errors++;
            $display("FAIL const_count got=%0d expected=400", got.size());
        end
        if (got[0] !== -16'sd245) begin
            errors++;
            $display("FAIL const_first got=%0d expected=-245", got[0]);
        end
        if (got[15] !== -16'sd3907) begin
            errors++;
            $display("FAIL const_warm got=%0d expected=-3907", got[15]);
        end
        if (got[271] !== 16'sd7812) begin
            errors++;
            $display("FAIL const_steady got=%0d expected=7812", got[271]);
        end
        for (int k = 0; k < got.size(); k++) begin
            logic signed [15:0] exp_l;
            exp_l = clip(model_q(k, 1000, 1'b0));
            vectors++;
            if (got[k] !== exp_l) begin
                errors++;
                $display("FAIL const_seq k=%0d got=%0d expected=%0d", k, got[k], exp_l);
            end
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        run_stream(1000, 400, 50, 1'b0);
        vectors++;
        if (got.size() != 400) begin
            errors++;
            $display("FAIL gaps_count got=%0d expected=400", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            logic signed [15:0] exp_l;
            exp_l = clip(model_q(k, 1000, 1'b0));
            vectors++;
            if (got[k] !== exp_l) begin
                errors++;
                $display("FAIL gaps_seq k=%0d got=%0d expected=%0d", k, got[k], exp_l);
            end
        end
    endtask

    task automatic test_sat();
        int nsat;
        nsat = 0;
        apply_reset();
        run_stream(32767, 300, 0, 1'b0);
        vectors++;
        if (got[299] !== 16'sd32767) begin
            errors++;
            $display("FAIL sat_steady got=%0d expected=32767", got[299]);
        end
        for (int k = 0; k < got.size(); k++) begin
            longint q;
            q = model_q(k, 32767, 1'b0);
            if (q > 32767 || q < -32768)
                nsat++;
            vectors++;
            if (got[k] !== clip(q)) begin
                errors++;
                $display("FAIL sat_seq k=%0d got=%0d expected=%0d", k, got[k], clip(q));
            end
        end
`ifdef LAMBDA_SAT_CNT_EN
        vectors++;
        if (sat_cnt !== 16'(nsat)) begin
            errors++;
            $display("FAIL sat_cnt got=%0d expected=%0d", sat_cnt, nsat);
        end
`endif
    endtask

    task automatic test_mid_reset();
        apply_reset();
        repeat (150) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            r_re     = 16'sd1000;
            r_im     = '0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (minus_valid !== 1'b0 || lambda !== 16'sd0) begin
                errors++;
                $display("FAIL midrst_hold minus_valid=%b lambda=%0d expected 0/0",
                         minus_valid, lambda);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            vectors++;
            if (minus_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale minus_valid=%b expected=0", minus_valid);
            end
        end
        run_stream(1000, 400, 0, 1'b0);
        vectors++;
        if (got[0] !== -16'sd245) begin
            errors++;
            $display("FAIL midrst_first got=%0d expected=-245", got[0]);
        end
        for (int k = 0; k < got.size(); k++) begin
            logic signed [15:0] exp_l;
            exp_l = clip(model_q(k, 1000, 1'b0));
            vectors++;
            if (got[k] !== exp_l) begin
                errors++;
                $display("FAIL midrst_seq k=%0d got=%0d expected=%0d", k, got[k], exp_l);
            end
        end
    endtask

    task automatic test_sign_flip();
        apply_reset();
        run_stream(1000, 400, 0, 1'b1);
        vectors++;
        if (got[271] !== 16'sd7812) begin
            errors++;
            $display("FAIL flip_steady got=%0d expected=7812", got[271]);
        end
        for (int k = 0; k < got.size(); k++) begin
            logic signed [15:0] exp_l;
            exp_l = clip(model_q(k, 1000, 1'b1));
            vectors++;
            if (got[k] !== exp_l) begin
                errors++;
                $display("FAIL flip_seq k=%0d got=%0d expected=%0d", k, got[k], exp_l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_const();
        test_gaps();
        test_sat();
        test_mid_reset();
        test_sign_flip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
